// File: rtl/tamagotchi_pkg.sv
// ---------------------------------------------------------------------------
// tamagotchi_pkg
// Shared definitions for the pet controller:
//   estado_t   - pet state codes driven on the estado bus
//   cmd_t      - button command codes produced by the classifier
//   classif_t  - internal states of the button classifier
// Helper functions map between commands and activity states.
// ---------------------------------------------------------------------------
package tamagotchi_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        DORMINDO   = 3'b001,
        COMENDO    = 3'b010,
        DANDO_AULA = 3'b011,
        MORTO      = 3'b100
    } estado_t;

    typedef enum logic [1:0] {
        CMD_NENHUM = 2'b00,
        CMD_COMER  = 2'b01,
        CMD_DORMIR = 2'b10,
        CMD_AULA   = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        CL_ARMADO = 2'b00,
        CL_JANELA = 2'b01,
        CL_ESPERA = 2'b10
    } classif_t;

    // Bit 0 is "b1 seen", bit 1 is "b2 seen": the code layout makes this a plain concatenation.
    function automatic cmd_t codifica_cmd(input logic b1_seen, input logic b2_seen);
        return cmd_t'({b2_seen, b1_seen});
    endfunction

    // Activity entered from IDLE for a given command.
    function automatic estado_t atividade_de(input cmd_t cmd);
        estado_t res;
        case (cmd)
            CMD_COMER:  res = COMENDO;
            CMD_DORMIR: res = DORMINDO;
            CMD_AULA:   res = DANDO_AULA;
            default:    res = IDLE;
        endcase
        return res;
    endfunction

    // Command that entered (and therefore leaves) an activity state.
    function automatic cmd_t cmd_de_entrada(input estado_t e);
        cmd_t res;
        case (e)
            COMENDO:    res = CMD_COMER;
            DORMINDO:   res = CMD_DORMIR;
            DANDO_AULA: res = CMD_AULA;
            default:    res = CMD_NENHUM;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/classificador_botoes.sv
// ---------------------------------------------------------------------------
// classificador_botoes
// Turns two level buttons into one command per press gesture. A rising edge
// on either button opens a JANELA-cycle window during which button levels are
// OR-accumulated; the result is then pulsed for one cycle. A new gesture is
// only accepted after both buttons have been released for a cycle.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_b1, i_b2    button levels, synchronous to i_clk
//   o_cmd_valid   one-cycle pulse when a command is ready
//   o_cmd         command code (CMD_COMER / CMD_DORMIR / CMD_AULA)
// ---------------------------------------------------------------------------
module classificador_botoes
    import tamagotchi_pkg::*;
#(
    parameter int JANELA = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_b1,
    input  logic       i_b2,
    output logic       o_cmd_valid,
    output logic [1:0] o_cmd
);

    localparam int CW = (JANELA > 1) ? $clog2(JANELA) : 1;

    classif_t      r_estado, w_estado_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_seen1, r_seen2, w_seen1_next, w_seen2_next;
    logic          r_b1_q, r_b2_q;
    logic          r_cmd_valid, w_cmd_valid_next;
    cmd_t          r_cmd, w_cmd_next;
    logic          w_borda;

    assign w_borda = (i_b1 & ~r_b1_q) | (i_b2 & ~r_b2_q);

    always_comb begin
        // NOTE: every signal this block drives gets a default first, so no path can leave it unassigned and infer a latch.
        w_estado_next    = r_estado;
        w_cnt_next       = r_cnt;
        w_seen1_next     = r_seen1;
        w_seen2_next     = r_seen2;
        w_cmd_valid_next = 1'b0;
        w_cmd_next       = CMD_NENHUM;

        case (r_estado)
            CL_ARMADO: begin
                if (w_borda) begin
                    // The edge cycle itself is the first cycle of the window.
                    w_seen1_next = i_b1;
                    w_seen2_next = i_b2;
                    w_cnt_next   = CW'(1);
                    if (JANELA == 1) begin
                        w_cmd_valid_next = 1'b1;
                        w_cmd_next       = codifica_cmd(i_b1, i_b2);
                        w_estado_next    = CL_ESPERA;
                    end else begin
                        w_estado_next = CL_JANELA;
                    end
                end
            end
            CL_JANELA: begin
                w_seen1_next = r_seen1 | i_b1;
                w_seen2_next = r_seen2 | i_b2;
                if (r_cnt == CW'(JANELA - 1)) begin
                    w_cmd_valid_next = 1'b1;
                    w_cmd_next       = codifica_cmd(w_seen1_next, w_seen2_next);
                    w_estado_next    = CL_ESPERA;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            CL_ESPERA: begin
                if (!i_b1 && !i_b2) w_estado_next = CL_ARMADO;
            end
            default: w_estado_next = CL_ARMADO;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the button history is reset too; otherwise a stale level could fake an edge after reset.
            r_estado    <= CL_ARMADO;
            r_cnt       <= '0;
            r_seen1     <= 1'b0;
            r_seen2     <= 1'b0;
            r_b1_q      <= 1'b0;
            r_b2_q      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_NENHUM;
        end else begin
            r_estado    <= w_estado_next;
            r_cnt       <= w_cnt_next;
            r_seen1     <= w_seen1_next;
            r_seen2     <= w_seen2_next;
            r_b1_q      <= i_b1;
            r_b2_q      <= i_b2;
            r_cmd_valid <= w_cmd_valid_next;
            r_cmd       <= w_cmd_next;
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;

endmodule

// File: rtl/controlador_tamagotchi_param.sv
// ---------------------------------------------------------------------------
// controlador_tamagotchi_param
// Main pet controller: state machine, three saturating attributes, rise
// (activity) and decay (time) counters, death on depletion and restart.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_b1, i_b2       button levels
//   o_estado         IDLE/DORMINDO/COMENDO/DANDO_AULA/MORTO
//   o_fome           satiety
//   o_felicidade     happiness
//   o_sono           rest
//   o_morte          one-cycle pulse on entry to MORTO
// ---------------------------------------------------------------------------
module controlador_tamagotchi_param
    import tamagotchi_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAX        = 100,
    parameter int PASSO      = 1,
    parameter int TICK_SOBE  = 66,
    parameter int TICK_DECAI = 200,
    parameter int JANELA     = 4,
    parameter int INIT_FOME  = 40,
    parameter int INIT_FELIC = 50,
    parameter int INIT_SONO  = 20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_b1,
    input  logic         i_b2,
    output logic [2:0]   o_estado,
    output logic [W-1:0] o_fome,
    output logic [W-1:0] o_felicidade,
    output logic [W-1:0] o_sono,
    output logic         o_morte
);

    localparam int SW = (TICK_SOBE > 1) ? $clog2(TICK_SOBE) : 1;
    localparam int DW = (TICK_DECAI > 1) ? $clog2(TICK_DECAI) : 1;

    estado_t       r_estado, w_estado_next;
    logic [W-1:0]  r_fome, r_felic, r_sono;
    logic [W-1:0]  w_fome_next, w_felic_next, w_sono_next;
    logic [SW-1:0] r_cnt_sobe, w_cnt_sobe_next;
    logic [DW-1:0] r_cnt_decai, w_cnt_decai_next;
    logic          r_morte;

    logic          w_cmd_valid;
    logic [1:0]    w_cmd_bits;
    cmd_t          w_cmd;
    logic          w_em_atividade, w_tick_sobe, w_tick_decai, w_reinicio, w_morre;

    classificador_botoes #(.JANELA(JANELA)) u_classificador (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_b1       (i_b1),
        .i_b2       (i_b2),
        .o_cmd_valid(w_cmd_valid),
        .o_cmd      (w_cmd_bits)
    );

    // Owned attribute only rises (never decays); the others only decay.
    // The rise sum is taken in W+1 bits so MAX close to 2**W cannot wrap.
    function automatic logic [W-1:0] atualiza(input logic [W-1:0] a, input logic dono,
                                              input logic sobe, input logic decai);
        logic [W:0]   soma;
        logic [W-1:0] res;
        soma = {1'b0, a} + (W+1)'(PASSO);
        res  = a;
        if (dono) begin
            if (sobe) res = (soma > (W+1)'(MAX)) ? W'(MAX) : soma[W-1:0];
        end else if (decai && a != '0) begin
            res = a - W'(1);
        end
        return res;
    endfunction

    always_comb begin
        w_cmd          = cmd_t'(w_cmd_bits);
        w_em_atividade = (r_estado == COMENDO) || (r_estado == DORMINDO) || (r_estado == DANDO_AULA);
        w_tick_sobe    = w_em_atividade && (r_cnt_sobe == SW'(TICK_SOBE - 1));
        w_tick_decai   = (r_estado != MORTO) && (r_cnt_decai == DW'(TICK_DECAI - 1));
        w_reinicio     = (r_estado == MORTO) && w_cmd_valid && (w_cmd == CMD_AULA);

        // Attributes: ticks use the pre-transition state, so a command that
        // leaves an activity this cycle still lets its owned attribute rise.
        w_fome_next  = r_fome;
        w_felic_next = r_felic;
        w_sono_next  = r_sono;
        if (r_estado == MORTO) begin
            if (w_reinicio) begin
                w_fome_next  = W'(INIT_FOME);
                w_felic_next = W'(INIT_FELIC);
                w_sono_next  = W'(INIT_SONO);
            end
        end else begin
            w_fome_next  = atualiza(r_fome,  r_estado == COMENDO,    w_tick_sobe, w_tick_decai);
            w_felic_next = atualiza(r_felic, r_estado == DANDO_AULA, w_tick_sobe, w_tick_decai);
            w_sono_next  = atualiza(r_sono,  r_estado == DORMINDO,   w_tick_sobe, w_tick_decai);
        end

        // Death looks at the updated values so it lands on the same edge as the depletion.
        w_morre = (r_estado != MORTO) &&
                  (w_fome_next == '0 || w_felic_next == '0 || w_sono_next == '0);

        w_estado_next = r_estado;
        if (w_cmd_valid) begin
            case (r_estado)
                IDLE:                          w_estado_next = atividade_de(w_cmd);
                COMENDO, DORMINDO, DANDO_AULA: if (w_cmd == cmd_de_entrada(r_estado)) w_estado_next = IDLE;
                MORTO:                         if (w_cmd == CMD_AULA) w_estado_next = IDLE;
                default:                       w_estado_next = IDLE;
            endcase
        end
        if (w_morre) w_estado_next = MORTO;

        // Rise counter only runs while staying in the same activity; any entry starts from zero.
        if (w_em_atividade && w_estado_next == r_estado)
            w_cnt_sobe_next = w_tick_sobe ? '0 : r_cnt_sobe + SW'(1);
        else
            w_cnt_sobe_next = '0;

        if (r_estado == MORTO)
            w_cnt_decai_next = w_reinicio ? '0 : r_cnt_decai;
        else
            w_cnt_decai_next = w_tick_decai ? '0 : r_cnt_decai + DW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_estado    <= IDLE;
            r_fome      <= W'(INIT_FOME);
            r_felic     <= W'(INIT_FELIC);
            r_sono      <= W'(INIT_SONO);
            r_cnt_sobe  <= '0;
            r_cnt_decai <= '0;
            r_morte     <= 1'b0;
        end else begin
            r_estado    <= w_estado_next;
            r_fome      <= w_fome_next;
            r_felic     <= w_felic_next;
            r_sono      <= w_sono_next;
            r_cnt_sobe  <= w_cnt_sobe_next;
            r_cnt_decai <= w_cnt_decai_next;
            r_morte     <= w_morre;
        end
    end

    assign o_estado     = r_estado;
    assign o_fome       = r_fome;
    assign o_felicidade = r_felic;
    assign o_sono       = r_sono;
    assign o_morte      = r_morte;

endmodule

// File: tb/tb_controlador_tamagotchi_param.sv
// ---------------------------------------------------------------------------
// tb_controlador_tamagotchi_param
// Bench for the pet controller with small parameters (MAX=10, TICK_SOBE=3,
// TICK_DECAI=10, JANELA=2, INIT=5/5/5). A cycle model derived from the
// behavioural rules runs alongside the DUT and is compared on every falling
// edge; directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_controlador_tamagotchi_param;

    localparam int W          = 8;
    localparam int MAX        = 10;
    localparam int PASSO      = 1;
    localparam int TICK_SOBE  = 3;
    localparam int TICK_DECAI = 10;
    localparam int JANELA     = 2;
    localparam int INIT       = 5;

    localparam int S_IDLE = 0, S_DORM = 1, S_COME = 2, S_AULA = 3, S_MORTO = 4;
    localparam int C_COMER = 1, C_DORMIR = 2, C_AULA = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         b1  = 1'b0;
    logic         b2  = 1'b0;
    logic [2:0]   estado;
    logic [W-1:0] fome, felic, sono;
    logic         morte;

    int vetores = 0;
    int falhas  = 0;
    int t       = 0;

    controlador_tamagotchi_param #(
        .W(W), .MAX(MAX), .PASSO(PASSO), .TICK_SOBE(TICK_SOBE), .TICK_DECAI(TICK_DECAI),
        .JANELA(JANELA), .INIT_FOME(INIT), .INIT_FELIC(INIT), .INIT_SONO(INIT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_b1        (b1),
        .i_b2        (b2),
        .o_estado    (estado),
        .o_fome      (fome),
        .o_felicidade(felic),
        .o_sono      (sono),
        .o_morte     (morte)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input int atual, input int esperado);
        vetores++;
        if (atual != esperado) begin
            falhas++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int estado;
        int fome;
        int felic;
        int sono;
        int morte;
        int ca;     // cycles spent in the current activity
        int cv;     // living cycles since reset/restart
        int pend;   // command acting on the next edge, -1 when none
        int wrem;   // window cycles still to sample
        bit espera; // waiting for both buttons released
        bit s1, s2, p1, p2;
    } modelo_t;

    modelo_t m;

    function automatic int ajusta(input int v, input bit dono, input bit sobe, input bit decai);
        if (dono) return sobe ? ((v + PASSO > MAX) ? MAX : v + PASSO) : v;
        return decai ? ((v > 0) ? v - 1 : 0) : v;
    endfunction

    function automatic modelo_t modelo_reset();
        modelo_t r;
        r.estado = S_IDLE; r.fome = INIT; r.felic = INIT; r.sono = INIT; r.morte = 0;
        r.ca = 0; r.cv = 0; r.pend = -1; r.wrem = 0; r.espera = 0;
        r.s1 = 0; r.s2 = 0; r.p1 = 0; r.p2 = 0;
        return r;
    endfunction

    function automatic modelo_t passo(input modelo_t a, input bit i1, input bit i2);
        modelo_t n;
        int      cmd;
        int      dono;
        bit      sobe, decai;
        n    = a;
        cmd  = a.pend;
        n.pend = -1;
        dono = (a.estado == S_COME) ? 0 : (a.estado == S_AULA) ? 1 : (a.estado == S_DORM) ? 2 : -1;
        sobe  = (dono >= 0) && (a.ca % TICK_SOBE == TICK_SOBE - 1);
        decai = (a.estado != S_MORTO) && (a.cv % TICK_DECAI == TICK_DECAI - 1);
        if (a.estado != S_MORTO) begin
            n.fome  = ajusta(a.fome,  dono == 0, sobe, decai);
            n.felic = ajusta(a.felic, dono == 1, sobe, decai);
            n.sono  = ajusta(a.sono,  dono == 2, sobe, decai);
            n.cv    = a.cv + 1;
        end
        if (cmd > 0) begin
            if (a.estado == S_IDLE)
                n.estado = (cmd == C_COMER) ? S_COME : (cmd == C_DORMIR) ? S_DORM : S_AULA;
            else if (a.estado == S_MORTO) begin
                if (cmd == C_AULA) begin
                    n.estado = S_IDLE; n.fome = INIT; n.felic = INIT; n.sono = INIT; n.cv = 0;
                end
            end else if ((a.estado == S_COME && cmd == C_COMER) ||
                         (a.estado == S_DORM && cmd == C_DORMIR) ||
                         (a.estado == S_AULA && cmd == C_AULA))
                n.estado = S_IDLE;
        end
        n.morte = 0;
        if (a.estado != S_MORTO && (n.fome == 0 || n.felic == 0 || n.sono == 0)) begin
            n.estado = S_MORTO;
            n.morte  = 1;
        end
        n.ca = (dono >= 0 && n.estado == a.estado) ? a.ca + 1 : 0;
        // button gesture classification
        if (a.wrem > 0) begin
            n.s1 = a.s1 | i1; n.s2 = a.s2 | i2; n.wrem = a.wrem - 1;
            if (n.wrem == 0) begin n.pend = (n.s2 ? 2 : 0) + (n.s1 ? 1 : 0); n.espera = 1; end
        end else if (a.espera) begin
            if (!i1 && !i2) n.espera = 0;
        end else if ((i1 && !a.p1) || (i2 && !a.p2)) begin
            n.s1 = i1; n.s2 = i2; n.wrem = JANELA - 1;
            if (n.wrem == 0) begin n.pend = (n.s2 ? 2 : 0) + (n.s1 ? 1 : 0); n.espera = 1; end
        end
        n.p1 = i1; n.p2 = i2;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= modelo_reset();
        else     m <= passo(m, b1, b2);
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("estado", int'(estado), m.estado);
            check("fome", int'(fome), m.fome);
            check("felicidade", int'(felic), m.felic);
            check("sono", int'(sono), m.sono);
            check("morte", int'(morte), m.morte);
        end
    end

    // ---------------- stimulus ----------------
    task automatic reinicia();
        @(negedge clk);
        #3;
        rst = 1'b1; b1 = 1'b0; b2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        t = 0;
    endtask

    // Advance to falling edge number alvo counted from reset release.
    task automatic ir(input int alvo);
        repeat (alvo - t) @(negedge clk);
        t = alvo;
    endtask

    initial begin
        // Scenario 1 / 5: feeding, rise timing, rise+decay together, saturation, exit.
        reinicia();
        check("reset_estado", int'(estado), 0);
        check("reset_fome", int'(fome), 5);
        check("reset_felic", int'(felic), 5);
        check("reset_sono", int'(sono), 5);
        check("reset_morte", int'(morte), 0);
        ir(1);  b1 = 1'b1;
        ir(2);  b1 = 1'b0;
        ir(3);  check("t1_antes_latencia", int'(estado), 0);
        ir(4);  check("t1_comendo", int'(estado), 2);
        ir(6);  check("t1_fome_pre_sobe", int'(fome), 5);
        ir(7);  check("t1_fome_sobe", int'(fome), 6);
        ir(9);  check("t5_felic_pre", int'(felic), 5);
        ir(10); check("t5_fome_sobe", int'(fome), 7);
                check("t5_felic_decai", int'(felic), 4);
                check("t5_sono_decai", int'(sono), 4);
        ir(25); check("t1_fome_sat", int'(fome), 10);
                b1 = 1'b1;
        ir(26); b1 = 1'b0;
        ir(27); check("t1_ainda_comendo", int'(estado), 2);
        ir(28); check("t1_volta_idle", int'(estado), 0);
                check("t1_fome_final", int'(fome), 10);
                check("t1_sono_final", int'(sono), 3);

        // Scenario 2: two-button gesture, ignored foreign command, exit with same gesture.
        reinicia();
        ir(1);  b1 = 1'b1;
        ir(2);  b2 = 1'b1;
        ir(3);  b1 = 1'b0; b2 = 1'b0;
        ir(4);  check("t2_aula", int'(estado), 3);
        ir(6);  b2 = 1'b1;
        ir(7);  b2 = 1'b0;
                check("t2_felic_sobe", int'(felic), 6);
        ir(9);  check("t2_dormir_ignorado", int'(estado), 3);
        ir(10); check("t2_fome_decai", int'(fome), 4);
                check("t2_felic", int'(felic), 7);
        ir(11); b1 = 1'b1;
        ir(12); b2 = 1'b1;
        ir(13); b1 = 1'b0; b2 = 1'b0;
                check("t2_ainda_aula", int'(estado), 3);
        ir(14); check("t2_volta_idle", int'(estado), 0);
                check("t2_felic_final", int'(felic), 8);

        // Scenario 3: starvation in IDLE, death pulse, frozen values.
        reinicia();
        ir(49); check("t3_fome_1", int'(fome), 1);
                check("t3_vivo", int'(estado), 0);
        ir(50); check("t3_morto", int'(estado), 4);
                check("t3_morte_pulso", int'(morte), 1);
                check("t3_sono_0", int'(sono), 0);
        ir(51); check("t3_morte_baixa", int'(morte), 0);
        ir(60); check("t3_congelado", int'(felic), 0);
                check("t3_continua_morto", int'(estado), 4);

        // Scenario 4: restart from MORTO.
        b1 = 1'b1;
        ir(62); b1 = 1'b0;
        ir(64); check("t4_comer_ignorado", int'(estado), 4);
        ir(66); b1 = 1'b1; b2 = 1'b1;
        ir(67); b1 = 1'b0; b2 = 1'b0;
        ir(68); check("t4_ainda_morto", int'(estado), 4);
        ir(69); check("t4_reinicio", int'(estado), 0);
                check("t4_fome_init", int'(fome), 5);
                check("t4_felic_init", int'(felic), 5);
        ir(78); check("t4_sem_decai", int'(sono), 5);
        ir(79); check("t4_decai_apos", int'(fome), 4);

        // Scenario 6: asynchronous reset mid-COMENDO and mid-window.
        reinicia();
        ir(1);  b1 = 1'b1;
        ir(2);  b1 = 1'b0;
        ir(4);  check("t6_comendo", int'(estado), 2);
        ir(10); b1 = 1'b1;
        ir(11);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_estado", int'(estado), 0);
        check("t6_rst_fome", int'(fome), 5);
        check("t6_rst_felic", int'(felic), 5);
        check("t6_rst_morte", int'(morte), 0);
        @(negedge clk);
        b1  = 1'b0;
        rst = 1'b0;
        t   = 0;
        ir(3);  check("t6_sem_cmd_3", int'(estado), 0);
        ir(8);  check("t6_sem_cmd_8", int'(estado), 0);
                check("t6_fome", int'(fome), 5);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
        $finish;
    end

endmodule
